// File: rtl/udcounter_seq_ctrl_if.sv
// Board-side and counter-side signal bundle for the up/down counter sequencer.
// The master modport is the board/counter side that drives buttons, switch and
// count feedback; the slave modport is the sequencer itself.
interface udcounter_seq_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   // Board buttons/switch and counter feedback
   logic             btn_start;
   logic             btn_stop;
   logic             btn_load;
   logic             sw_dir;
   logic [WIDTH-1:0] count_in;

   // Counter controls and status
   logic             start;
   logic             stop;
   logic             load;
   logic             updown;
   logic             busy;
   logic [1:0]       state_o;
   logic             term_pulse;

   modport master (
      output btn_start,
      output btn_stop,
      output btn_load,
      output sw_dir,
      output count_in,
      input  start,
      input  stop,
      input  load,
      input  updown,
      input  busy,
      input  state_o,
      input  term_pulse
   );

   modport slave (
      input  btn_start,
      input  btn_stop,
      input  btn_load,
      input  sw_dir,
      input  count_in,
      output start,
      output stop,
      output load,
      output updown,
      output busy,
      output state_o,
      output term_pulse
   );
endinterface

// File: rtl/udcounter_seq_ctrl.sv
// Sequencer for the 8-bit up/down counter: rise-detects the board buttons, runs an
// IDLE/RUN/PAUSE/LOAD state machine and flags terminal counts from count feedback.
// All outputs are registered; reset is synchronous and active-high.
// Optional feature macro: AUTO_REVERSE_EN -- ping-pong between LIMIT_LO and LIMIT_HI
// instead of free wrapping; sw_dir toggles still override the direction.
module udcounter_seq_ctrl #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned LIMIT_HI = 255,
   parameter int unsigned LIMIT_LO = 0
) (
   input logic                   clk,
   input logic                   reset,
   udcounter_seq_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StLoad  = 2'd3
   } state_e;

   // Turn-around points only make sense with at least one value strictly between them
   if (LIMIT_HI <= LIMIT_LO + 1) begin : g_limit_check
      $error("udcounter_seq_ctrl: LIMIT_HI must be greater than LIMIT_LO+1");
   end

   logic   btn_start_q, btn_stop_q, btn_load_q;
   logic   rise_start, rise_stop, rise_load;

   state_e state_q;
   state_e ret_q;     // state to resume after the one-cycle LOAD
   logic   start_q, stop_q, load_q, busy_q;

   logic   updown_q, updown_d;
   logic   term_q;
   logic   armed_q;   // cleared after a terminal pulse until count_in moves off the value
   logic   at_term;
   logic   hit;

   // Button history; cleared by reset so a button held through reset fires once after it
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_start_q <= 1'b0;
         btn_stop_q  <= 1'b0;
         btn_load_q  <= 1'b0;
      end else begin
         btn_start_q <= bus.btn_start;
         btn_stop_q  <= bus.btn_stop;
         btn_load_q  <= bus.btn_load;
      end
   end

   assign rise_start = bus.btn_start & ~btn_start_q;
   assign rise_stop  = bus.btn_stop  & ~btn_stop_q;
   assign rise_load  = bus.btn_load  & ~btn_load_q;

   // Sequencer FSM with registered controls; load beats stop beats start
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         ret_q   <= StIdle;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         load_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (rise_load) begin
                  state_q <= StLoad;
                  ret_q   <= StIdle;
                  load_q  <= 1'b1;
                  start_q <= 1'b0;
                  stop_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (rise_start) begin
                  state_q <= StRun;
                  start_q <= 1'b1;
                  stop_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            StRun: begin
               if (rise_load) begin
                  state_q <= StLoad;
                  ret_q   <= StRun;
                  load_q  <= 1'b1;
                  start_q <= 1'b1;
                  stop_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (rise_stop) begin
                  state_q <= StPause;
                  start_q <= 1'b1;
                  stop_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            StPause: begin
               if (rise_load) begin
                  state_q <= StLoad;
                  ret_q   <= StPause;
                  load_q  <= 1'b1;
                  start_q <= 1'b1;
                  stop_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else if (rise_start) begin
                  state_q <= StRun;
                  start_q <= 1'b1;
                  stop_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            StLoad: begin
               // Rises seen here are dropped; start/stop already carry the return state's values
               state_q <= ret_q;
               start_q <= (ret_q == StRun) || (ret_q == StPause);
               stop_q  <= (ret_q == StPause);
               busy_q  <= (ret_q == StRun);
            end
         endcase
      end
   end

`ifdef AUTO_REVERSE_EN
   localparam logic [WIDTH-1:0] HiV  = WIDTH'(LIMIT_HI);
   localparam logic [WIDTH-1:0] LoV  = WIDTH'(LIMIT_LO);
   localparam logic [WIDTH-1:0] HiM1 = WIDTH'(LIMIT_HI - 1);
   localparam logic [WIDTH-1:0] LoP1 = WIDTH'(LIMIT_LO + 1);

   logic sw_dir_q;
   logic prev_up_q;   // direction the counter used on the last edge

   // Switch history and last-used direction
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_dir_q  <= 1'b0;
         prev_up_q <= 1'b0;
      end else begin
         sw_dir_q  <= bus.sw_dir;
         prev_up_q <= updown_q;
      end
   end

   // Reverse one step early so the counter turns exactly at the limits; a switch toggle wins
   always_comb begin
      updown_d = updown_q;
      if (bus.sw_dir != sw_dir_q) begin
         updown_d = bus.sw_dir;
      end else if (state_q == StRun) begin
         if (updown_q && (bus.count_in == HiM1)) begin
            updown_d = 1'b0;
         end else if (!updown_q && (bus.count_in == LoP1)) begin
            updown_d = 1'b1;
         end
      end
   end

   // updown has already flipped when a limit is reached, so qualify by the direction used
   assign at_term = ((bus.count_in == HiV) &&  prev_up_q) ||
                    ((bus.count_in == LoV) && !prev_up_q);
`else
   assign updown_d = bus.sw_dir;
   assign at_term  = updown_q ? (bus.count_in == '1) : (bus.count_in == '0);
`endif

   assign hit = (state_q == StRun) && at_term && armed_q;

   // Direction register and single-shot terminal-count flag
   always_ff @(posedge clk) begin
      if (reset) begin
         updown_q <= 1'b0;
         term_q   <= 1'b0;
         armed_q  <= 1'b1;
      end else begin
         updown_q <= updown_d;
         term_q   <= hit;
         if (!at_term) begin
            armed_q <= 1'b1;
         end else if (hit) begin
            armed_q <= 1'b0;
         end
      end
   end

   assign bus.start      = start_q;
   assign bus.stop       = stop_q;
   assign bus.load       = load_q;
   assign bus.updown     = updown_q;
   assign bus.busy       = busy_q;
   assign bus.state_o    = state_q;
   assign bus.term_pulse = term_q;

endmodule
